// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: bus widths,
// access-size encodings, FSM states and size-derived mask helpers.
package mem_lsu_pkg;

  localparam int DATA_BUS = 64;
  localparam int ADDR_BUS = 64;

  localparam logic [1:0] MEM_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF  = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD  = 2'd2;
  localparam logic [1:0] MEM_SIZE_DWORD = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      MEM_SIZE_BYTE:  mask = 3'b000;
      MEM_SIZE_HALF:  mask = 3'b001;
      MEM_SIZE_WORD:  mask = 3'b011;
      MEM_SIZE_DWORD: mask = 3'b111;
      default:        mask = 3'b111;
    endcase
    return mask;
  endfunction

  // Byte enables for an access of the given size at offset zero.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      MEM_SIZE_BYTE:  mask = 8'h01;
      MEM_SIZE_HALF:  mask = 8'h03;
      MEM_SIZE_WORD:  mask = 8'h0F;
      MEM_SIZE_DWORD: mask = 8'hFF;
      default:        mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory port: valid/ready request channel plus a valid-only response
// channel that also serves as the write acknowledgement.
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_BUS,
  parameter int ADDR_W = ADDR_BUS
) ();

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic [7:0]        dmem_req_wmask;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

endinterface

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatting: store lane placement and byte enables,
// load lane extraction with sign or zero extension.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic [1:0]        store_size,
  input  logic [2:0]        store_off,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wmask,
  input  logic [1:0]        load_size,
  input  logic [2:0]        load_off,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] raw_s;
  logic              sign_s;

  // Store side: shift rs2 into its byte lanes and enable only those lanes.
  always_comb begin
    wdata = store_data << {store_off, 3'b000};
    wmask = size_byte_mask(store_size) << store_off;
  end

  // Load side: bring the addressed lanes down to bit 0, then extend.
  always_comb begin
    raw_s  = rdata >> {load_off, 3'b000};
    sign_s = 1'b0;
    case (load_size)
      MEM_SIZE_BYTE: begin
        sign_s    = raw_s[7] & ~load_unsigned;
        load_data = {{(DATA_W-8){sign_s}}, raw_s[7:0]};
      end
      MEM_SIZE_HALF: begin
        sign_s    = raw_s[15] & ~load_unsigned;
        load_data = {{(DATA_W-16){sign_s}}, raw_s[15:0]};
      end
      MEM_SIZE_WORD: begin
        sign_s    = raw_s[31] & ~load_unsigned;
        load_data = {{(DATA_W-32){sign_s}}, raw_s[31:0]};
      end
      MEM_SIZE_DWORD: begin
        load_data = raw_s;
      end
      default: begin
        load_data = raw_s;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one aligned memory transaction per memory
// instruction, pipeline stall while outstanding, 1-cycle pass-through otherwise.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_BUS,
  parameter int ADDR_W = ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inst_load,
  input  logic              inst_store,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] ex_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign,
  mem_lsu_if.master         dmem
);

  lsu_state_e        state_r, state_nxt_s;

  logic              out_valid_r, out_misalign_r;
  logic [DATA_W-1:0] out_data_r;
  logic              req_valid_r, req_we_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_wdata_r;
  logic [7:0]        req_wmask_r;
  logic [2:0]        off_r;
  logic [1:0]        size_r;
  logic              unsigned_r;

  logic              is_mem_s, misalign_s;
  logic              accept_pass_s, accept_mis_s, accept_mem_s;
  logic              req_fire_s, resp_fire_s;
  logic [DATA_W-1:0] fmt_wdata_s, load_data_s;
  logic [7:0]        fmt_wmask_s;

  assign is_mem_s   = inst_load | inst_store;
  assign misalign_s = |(addr[2:0] & size_align_mask(mem_size));

  // Store fields come from the live EX inputs; load fields from the latched access.
  mem_lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
    .store_size    (mem_size),
    .store_off     (addr[2:0]),
    .store_data    (store_data),
    .wdata         (fmt_wdata_s),
    .wmask         (fmt_wmask_s),
    .load_size     (size_r),
    .load_off      (off_r),
    .load_unsigned (unsigned_r),
    .rdata         (dmem.dmem_resp_rdata),
    .load_data     (load_data_s)
  );

  // Next-state and per-cycle event strobes.
  always_comb begin
    state_nxt_s   = state_r;
    in_ready      = 1'b0;
    accept_pass_s = 1'b0;
    accept_mis_s  = 1'b0;
    accept_mem_s  = 1'b0;
    req_fire_s    = 1'b0;
    resp_fire_s   = 1'b0;
    case (state_r)
      LSU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !is_mem_s) begin
          accept_pass_s = 1'b1;
        end else if (in_valid && misalign_s) begin
          accept_mis_s = 1'b1;
        end else if (in_valid) begin
          accept_mem_s = 1'b1;
          state_nxt_s  = LSU_REQ;
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (dmem.dmem_req_ready) begin
          req_fire_s  = 1'b1;
          state_nxt_s = LSU_RESP;
        end else begin
          state_nxt_s = LSU_REQ;
        end
      end
      LSU_RESP: begin
        if (dmem.dmem_resp_valid) begin
          resp_fire_s = 1'b1;
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_RESP;
        end
      end
      LSU_DONE: begin
        state_nxt_s = LSU_IDLE;
      end
      default: begin
        state_nxt_s = LSU_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result and request registers; out_valid is a single-cycle pulse by default-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r    <= 1'b0;
      out_misalign_r <= 1'b0;
      out_data_r     <= {DATA_W{1'b0}};
      req_valid_r    <= 1'b0;
      req_we_r       <= 1'b0;
      req_addr_r     <= {ADDR_W{1'b0}};
      req_wdata_r    <= {DATA_W{1'b0}};
      req_wmask_r    <= 8'h00;
      off_r          <= 3'd0;
      size_r         <= 2'd0;
      unsigned_r     <= 1'b0;
    end else begin
      out_valid_r    <= 1'b0;
      out_misalign_r <= 1'b0;
      if (accept_pass_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ex_data;
      end else if (accept_mis_s) begin
        out_valid_r    <= 1'b1;
        out_misalign_r <= 1'b1;
        out_data_r     <= {DATA_W{1'b0}};
      end else if (accept_mem_s) begin
        req_valid_r <= 1'b1;
        req_we_r    <= inst_store;
        req_addr_r  <= {addr[ADDR_W-1:3], 3'b000};
        req_wdata_r <= inst_store ? fmt_wdata_s : {DATA_W{1'b0}};
        req_wmask_r <= inst_store ? fmt_wmask_s : 8'h00;
        off_r       <= addr[2:0];
        size_r      <= mem_size;
        unsigned_r  <= load_unsigned;
      end else if (req_fire_s) begin
        req_valid_r <= 1'b0;
      end else if (resp_fire_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= req_we_r ? {DATA_W{1'b0}} : load_data_s;
      end else begin
        req_valid_r <= req_valid_r;
      end
    end
  end

  assign out_valid           = out_valid_r;
  assign out_data            = out_data_r;
  assign out_misalign        = out_misalign_r;
  assign dmem.dmem_req_valid = req_valid_r;
  assign dmem.dmem_req_we    = req_we_r;
  assign dmem.dmem_req_addr  = req_addr_r;
  assign dmem.dmem_req_wdata = req_wdata_r;
  assign dmem.dmem_req_wmask = req_wmask_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, inst_load, inst_store, load_unsigned;
  logic [1:0]  mem_size;
  logic [63:0] addr, store_data, ex_data, out_data;
  logic        out_valid, out_misalign;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  mem_lsu_if #(.DATA_W(64), .ADDR_W(64)) dmem_bus ();

  mem_lsu #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inst_load     (inst_load),
    .inst_store    (inst_store),
    .mem_size      (mem_size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .store_data    (store_data),
    .ex_data       (ex_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_misalign  (out_misalign),
    .dmem          (dmem_bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] off,
                                          input logic [1:0] sz, input logic uns);
    int          nb;
    logic [63:0] raw, lo;
    nb  = 1 << sz;
    raw = rd >> (8 * off);
    if (nb == 8) return raw;
    lo  = (64'd1 << (8 * nb)) - 64'd1;
    raw = raw & lo;
    if (!uns && raw[8*nb-1]) raw = raw | ~lo;
    return raw;
  endfunction

  function automatic logic [7:0] m_wmask(input logic [2:0] off, input logic [1:0] sz);
    logic [15:0] m;
    m = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic m_misaligned(input logic [63:0] a, input logic [1:0] sz);
    return (a % (64'd1 << sz)) != 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; inst_load = 1'b0; inst_store = 1'b0; mem_size = 2'd0;
    load_unsigned = 1'b0; addr = 64'd0; store_data = 64'd0; ex_data = 64'd0;
    dmem_bus.dmem_req_ready = 1'b0; dmem_bus.dmem_resp_valid = 1'b0;
    dmem_bus.dmem_resp_rdata = 64'd0;
  endtask

  // One instruction end to end, with memory wait states and an optional early response.
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] sd, input logic [63:0] exd,
                       input logic [63:0] rd, input int rdly, input int respdly,
                       input logic junk, input logic [63:0] exp_data, input string tag);
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wmask;
    exp_addr  = a & ~64'd7;
    exp_wdata = sd << (8 * a[2:0]);
    exp_wmask = m_wmask(a[2:0], sz);

    total_cnt++; if (in_ready !== 1'b1) $display("FAIL %s ready_before got=%0b exp=1", tag, in_ready); else pass_cnt++;
    in_valid = 1'b1; inst_load = ld; inst_store = st; mem_size = sz; load_unsigned = uns;
    addr = a; store_data = sd; ex_data = exd;
    step();

    if (!(ld || st)) begin
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL %s pass_valid got=%0b exp=1", tag, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== exp_data) $display("FAIL %s pass_data got=%h exp=%h", tag, out_data, exp_data); else pass_cnt++;
      total_cnt++; if (out_misalign !== 1'b0) $display("FAIL %s pass_mis got=%0b exp=0", tag, out_misalign); else pass_cnt++;
      total_cnt++; if (dmem_bus.dmem_req_valid !== 1'b0) $display("FAIL %s pass_noreq got=%0b exp=0", tag, dmem_bus.dmem_req_valid); else pass_cnt++;
      return;
    end

    if (m_misaligned(a, sz)) begin
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL %s mis_valid got=%0b exp=1", tag, out_valid); else pass_cnt++;
      total_cnt++; if (out_misalign !== 1'b1) $display("FAIL %s mis_flag got=%0b exp=1", tag, out_misalign); else pass_cnt++;
      total_cnt++; if (out_data !== 64'd0) $display("FAIL %s mis_data got=%h exp=0", tag, out_data); else pass_cnt++;
      total_cnt++; if (dmem_bus.dmem_req_valid !== 1'b0) $display("FAIL %s mis_noreq got=%0b exp=0", tag, dmem_bus.dmem_req_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL %s mis_ready got=%0b exp=1", tag, in_ready); else pass_cnt++;
      return;
    end

    // Request phase: EX keeps in_valid high during the stall; it must be ignored.
    for (int i = 0; i <= rdly; i++) begin
      total_cnt++; if (dmem_bus.dmem_req_valid !== 1'b1) $display("FAIL %s req_valid got=%0b exp=1", tag, dmem_bus.dmem_req_valid); else pass_cnt++;
      total_cnt++; if (dmem_bus.dmem_req_addr !== exp_addr) $display("FAIL %s req_addr got=%h exp=%h", tag, dmem_bus.dmem_req_addr, exp_addr); else pass_cnt++;
      total_cnt++; if (dmem_bus.dmem_req_we !== st) $display("FAIL %s req_we got=%0b exp=%0b", tag, dmem_bus.dmem_req_we, st); else pass_cnt++;
      if (st) begin
        total_cnt++; if (dmem_bus.dmem_req_wdata !== exp_wdata) $display("FAIL %s req_wdata got=%h exp=%h", tag, dmem_bus.dmem_req_wdata, exp_wdata); else pass_cnt++;
        total_cnt++; if (dmem_bus.dmem_req_wmask !== exp_wmask) $display("FAIL %s req_wmask got=%h exp=%h", tag, dmem_bus.dmem_req_wmask, exp_wmask); else pass_cnt++;
      end
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL %s req_stall got=%0b exp=0", tag, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s req_noout got=%0b exp=0", tag, out_valid); else pass_cnt++;
      if (i < rdly) begin
        dmem_bus.dmem_req_ready = 1'b0;
        step();
      end
    end

    in_valid = 1'b0;
    dmem_bus.dmem_req_ready = 1'b1;
    if (junk) begin
      dmem_bus.dmem_resp_valid = 1'b1;
      dmem_bus.dmem_resp_rdata = ~rd;
    end
    step();
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_resp_valid = 1'b0;
    total_cnt++; if (dmem_bus.dmem_req_valid !== 1'b0) $display("FAIL %s req_drop got=%0b exp=0", tag, dmem_bus.dmem_req_valid); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s resp_noout got=%0b exp=0", tag, out_valid); else pass_cnt++;

    for (int i = 0; i < respdly; i++) begin
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s wait_noout got=%0b exp=0", tag, out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL %s wait_stall got=%0b exp=0", tag, in_ready); else pass_cnt++;
    end

    dmem_bus.dmem_resp_valid = 1'b1;
    dmem_bus.dmem_resp_rdata = rd;
    step();
    dmem_bus.dmem_resp_valid = 1'b0;
    dmem_bus.dmem_resp_rdata = {$urandom, $urandom};
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL %s done_valid got=%0b exp=1", tag, out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== exp_data) $display("FAIL %s done_data got=%h exp=%h", tag, out_data, exp_data); else pass_cnt++;
    total_cnt++; if (out_misalign !== 1'b0) $display("FAIL %s done_mis got=%0b exp=0", tag, out_misalign); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL %s done_stall got=%0b exp=0", tag, in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s single_pulse got=%0b exp=0", tag, out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL %s back_idle got=%0b exp=1", tag, in_ready); else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 64'd0) $display("FAIL rst_out_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (out_misalign !== 1'b0) $display("FAIL rst_misalign got=%0b exp=0", out_misalign); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_valid !== 1'b0) $display("FAIL rst_req_valid got=%0b exp=0", dmem_bus.dmem_req_valid); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_we !== 1'b0) $display("FAIL rst_req_we got=%0b exp=0", dmem_bus.dmem_req_we); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_addr !== 64'd0) $display("FAIL rst_req_addr got=%h exp=0", dmem_bus.dmem_req_addr); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_wdata !== 64'd0) $display("FAIL rst_req_wdata got=%h exp=0", dmem_bus.dmem_req_wdata); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_wmask !== 8'd0) $display("FAIL rst_req_wmask got=%h exp=0", dmem_bus.dmem_req_wmask); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'h1234, 64'd0, 0, 0, 1'b0, 64'h1234, "pass");
    do_op(1'b1, 1'b0, MEM_SIZE_BYTE, 1'b0, 64'h1003, 64'd0, 64'd0, 64'h00000000_80000000,
          0, 0, 1'b0, 64'hFFFFFFFF_FFFFFF80, "lb_signed");
    do_op(1'b0, 1'b1, MEM_SIZE_HALF, 1'b0, 64'h2006, 64'hABCD, 64'd0, 64'd0,
          3, 1, 1'b0, 64'd0, "sh_backpressure");
    do_op(1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 64'h3002, 64'd0, 64'd0, 64'd0,
          0, 0, 1'b0, 64'd0, "misaligned_word");
    do_op(1'b1, 1'b0, MEM_SIZE_WORD, 1'b1, 64'h4004, 64'd0, 64'd0, 64'hF0000000_00000000,
          0, 2, 1'b1, 64'h00000000_F0000000, "lwu");
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      in_valid = 1'b1; inst_load = 1'b0; inst_store = 1'b0; ex_data = d;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== d) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, d); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, in_ready); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_end got=%0b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_in_resp();
    in_valid = 1'b1; inst_load = 1'b1; inst_store = 1'b0; mem_size = MEM_SIZE_DWORD;
    addr = 64'h5000;
    step();
    in_valid = 1'b0;
    dmem_bus.dmem_req_ready = 1'b1;
    step();
    dmem_bus.dmem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rresp_ready got=%0b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (dmem_bus.dmem_req_addr !== 64'd0) $display("FAIL rresp_addr got=%h exp=0", dmem_bus.dmem_req_addr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rresp_out got=%0b exp=0", out_valid); else pass_cnt++;
    step();
    dmem_bus.dmem_resp_valid = 1'b1;
    dmem_bus.dmem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
    step();
    dmem_bus.dmem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stale_out[%0d] got=%0b exp=0", i, out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stale_ready[%0d] got=%0b exp=1", i, in_ready); else pass_cnt++;
      step();
    end
    do_op(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'h55AA, 64'd0, 0, 0, 1'b0, 64'h55AA, "after_rst");
  endtask

  task automatic test_random();
    logic [63:0] a, sd, exd, rd, exp_v;
    logic [1:0]  sz;
    logic        uns, ld, st;
    int          kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      ld   = (kind == 1);
      st   = (kind == 2);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      sd   = {$urandom, $urandom};
      exd  = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      if (kind == 0)      exp_v = exd;
      else if (kind == 1) exp_v = m_load(rd, a[2:0], sz, uns);
      else                exp_v = 64'd0;
      do_op(ld, st, sz, uns, a, sd, exd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), exp_v, $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
